// File: rtl/ccip_lane_sum_engine_pkg.sv
// Shared types and constants for the lane-sum reduction engine.
package ccip_lane_sum_pkg;

    localparam int LINE_W = 512;
    localparam int ADDR_W = 42;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } t_state;

    localparam logic [1:0] CSR_SRC   = 2'd0;
    localparam logic [1:0] CSR_DST   = 2'd1;
    localparam logic [1:0] CSR_START = 2'd2;
    localparam logic [1:0] CSR_CLEAR = 2'd3;

    function automatic int lane_count(input int elem_w);
        return LINE_W / elem_w;
    endfunction

endpackage

// File: rtl/ccip_lane_sum_engine_if.sv
// CSR, c0 read and c1 write channels of the lane-sum engine; slave = engine side.
interface ccip_lane_sum_engine_if;
    import ccip_lane_sum_pkg::*;

    logic              csr_wr_valid;
    logic [1:0]        csr_wr_idx;
    logic [63:0]       csr_wr_data;
    logic              busy;
    logic              done;
    logic              err;
    logic              rd_req_valid;
    logic [ADDR_W-1:0] rd_req_addr;
    logic [15:0]       rd_req_mdata;
    logic              rd_almfull;
    logic              rd_rsp_valid;
    logic [LINE_W-1:0] rd_rsp_data;
    logic              wr_req_valid;
    logic [ADDR_W-1:0] wr_req_addr;
    logic [LINE_W-1:0] wr_req_data;
    logic              wr_almfull;

    modport slave (
        input  csr_wr_valid, csr_wr_idx, csr_wr_data,
        input  rd_almfull, rd_rsp_valid, rd_rsp_data, wr_almfull,
        output busy, done, err,
        output rd_req_valid, rd_req_addr, rd_req_mdata,
        output wr_req_valid, wr_req_addr, wr_req_data
    );

    modport master (
        output csr_wr_valid, csr_wr_idx, csr_wr_data,
        output rd_almfull, rd_rsp_valid, rd_rsp_data, wr_almfull,
        input  busy, done, err,
        input  rd_req_valid, rd_req_addr, rd_req_mdata,
        input  wr_req_valid, wr_req_addr, wr_req_data
    );

endinterface

// File: rtl/ccip_lane_sum_engine_acc.sv
// LANES-wide lane accumulator. Define CCIP_LANE_SUM_SATURATE_EN for unsigned
// saturating lane adds; otherwise lanes wrap modulo 2^ELEM_W.
module ccip_lane_sum_acc
    import ccip_lane_sum_pkg::*;
#(
    parameter int ELEM_W = 32,
    parameter int LANES  = lane_count(ELEM_W)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr_i,
    input  logic              add_i,
    input  logic [LINE_W-1:0] data_i,
    output logic [LINE_W-1:0] acc_o
);

    logic [LINE_W-1:0] acc_q, acc_d;
`ifdef CCIP_LANE_SUM_SATURATE_EN
    logic [ELEM_W:0] sum_w;
`endif

    always_comb begin
        acc_d = acc_q;
`ifdef CCIP_LANE_SUM_SATURATE_EN
        sum_w = '0;
`endif
        if (clr_i) begin
            acc_d = '0;
        end else if (add_i) begin
            for (int i = 0; i < LANES; i++) begin
`ifdef CCIP_LANE_SUM_SATURATE_EN
                // carry out of the lane means the true sum exceeds the lane range
                sum_w = {1'b0, acc_q[i*ELEM_W +: ELEM_W]} + {1'b0, data_i[i*ELEM_W +: ELEM_W]};
                acc_d[i*ELEM_W +: ELEM_W] = sum_w[ELEM_W] ? {ELEM_W{1'b1}} : sum_w[ELEM_W-1:0];
`else
                acc_d[i*ELEM_W +: ELEM_W] = acc_q[i*ELEM_W +: ELEM_W] + data_i[i*ELEM_W +: ELEM_W];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) acc_q <= '0;
        else          acc_q <= acc_d;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/ccip_lane_sum_engine.sv
// Host-memory lane-sum engine: reads NUM_LINES lines from SRC, adds them lane-wise,
// writes the result line to DST. Saturation via CCIP_LANE_SUM_SATURATE_EN (in the accumulator).
//   state | meaning
//   IDLE  | waiting for a start write, SRC/DST writable
//   READ  | issuing reads and accumulating responses
//   WRITE | waiting for c1 space to send the result line
//   DONE  | result written, SRC/DST writable, new start accepted
module ccip_lane_sum_engine
    import ccip_lane_sum_pkg::*;
#(
    parameter int ELEM_W          = 32,
    parameter int MAX_LINES       = 1024,
    parameter int MAX_OUTSTANDING = 8
) (
    input logic                   clk,
    input logic                   reset_n,
    ccip_lane_sum_engine_if.slave bus
);

    localparam int         LANES       = lane_count(ELEM_W);
    localparam logic [6:0]  MAX_OUT_C   = 7'(MAX_OUTSTANDING);
    localparam logic [31:0] MAX_LINES_C = 32'(MAX_LINES);

    t_state            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, rd_addr_q, rd_addr_d;
    logic [31:0]       num_q, num_d, issued_q, issued_d, received_q, received_d;
    logic [6:0]        outst_q, outst_d;
    logic [15:0]       mdata_q, mdata_d;
    logic              done_q, done_d, err_q, err_d;
    logic              rd_valid_q, rd_valid_d, wr_valid_q, wr_valid_d;

    logic              idle_w, start_w, issue_w, rsp_w;
    logic [31:0]       csr_n_w;
    logic [LINE_W-1:0] acc_w;
    logic              unused_csr_hi;

    assign idle_w  = (state_q == IDLE) || (state_q == DONE);
    assign csr_n_w = bus.csr_wr_data[31:0];
    assign start_w = idle_w && bus.csr_wr_valid && (bus.csr_wr_idx == CSR_START)
                     && (csr_n_w <= MAX_LINES_C);
    assign issue_w = (state_q == READ) && (issued_q < num_q) && (outst_q < MAX_OUT_C)
                     && !bus.rd_almfull;
    // responses with nothing outstanding cannot belong to this job
    assign rsp_w   = (state_q == READ) && bus.rd_rsp_valid && (outst_q != '0);
    assign unused_csr_hi = ^bus.csr_wr_data[63:ADDR_W];

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        num_d      = num_q;
        issued_d   = issued_q;
        received_d = received_q;
        outst_d    = outst_q;
        mdata_d    = mdata_q;
        rd_addr_d  = rd_addr_q;
        done_d     = done_q;
        err_d      = err_q;
        rd_valid_d = 1'b0;
        wr_valid_d = 1'b0;

        if (bus.csr_wr_valid) begin
            case (bus.csr_wr_idx)
                CSR_SRC: if (idle_w) src_d = bus.csr_wr_data[ADDR_W-1:0];
                CSR_DST: if (idle_w) dst_d = bus.csr_wr_data[ADDR_W-1:0];
                CSR_START: begin
                    if (idle_w) begin
                        if (csr_n_w > MAX_LINES_C) begin
                            err_d = 1'b1;
                        end else begin
                            num_d      = csr_n_w;
                            issued_d   = '0;
                            received_d = '0;
                            outst_d    = '0;
                            done_d     = 1'b0;
                            state_d    = (csr_n_w == '0) ? WRITE : READ;
                        end
                    end
                end
                CSR_CLEAR: begin
                    done_d = 1'b0;
                    err_d  = 1'b0;
                end
            endcase
        end

        case (state_q)
            READ: begin
                if (issue_w) begin
                    rd_valid_d = 1'b1;
                    rd_addr_d  = src_q + ADDR_W'(issued_q);
                    mdata_d    = issued_q[15:0];
                    issued_d   = issued_q + 32'd1;
                end
                if (rsp_w) received_d = received_q + 32'd1;
                outst_d = outst_q + {6'b0, issue_w} - {6'b0, rsp_w};
                if (rsp_w && (received_q + 32'd1 == num_q)) state_d = WRITE;
            end
            WRITE: begin
                if (!bus.wr_almfull) begin
                    wr_valid_d = 1'b1;
                    done_d     = 1'b1;
                    state_d    = DONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            num_q      <= '0;
            issued_q   <= '0;
            received_q <= '0;
            outst_q    <= '0;
            mdata_q    <= '0;
            rd_addr_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            num_q      <= num_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            outst_q    <= outst_d;
            mdata_q    <= mdata_d;
            rd_addr_q  <= rd_addr_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            wr_valid_q <= wr_valid_d;
        end
    end

    ccip_lane_sum_acc #(
        .ELEM_W (ELEM_W),
        .LANES  (LANES)
    ) u_acc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (start_w),
        .add_i   (rsp_w),
        .data_i  (bus.rd_rsp_data),
        .acc_o   (acc_w)
    );

    assign bus.busy         = (state_q == READ) || (state_q == WRITE);
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.rd_req_valid = rd_valid_q;
    assign bus.rd_req_addr  = rd_addr_q;
    assign bus.rd_req_mdata = mdata_q;
    assign bus.wr_req_valid = wr_valid_q;
    assign bus.wr_req_addr  = dst_q;
    assign bus.wr_req_data  = acc_w;

endmodule

// File: tb/tb_ccip_lane_sum_engine.sv
// Directed bench for the lane-sum engine: an 8-bit-lane and a 32-bit-lane instance
// share one host model; sel picks which one is being exercised.
module tb_ccip_lane_sum_engine;
    import ccip_lane_sum_pkg::*;

`ifdef CCIP_LANE_SUM_SATURATE_EN
    localparam logic [511:0] EXP_F0X2  = 512'hFF;
    localparam logic [511:0] EXP_1X1024 = 512'hFF;
`else
    localparam logic [511:0] EXP_F0X2  = 512'hE0;
    localparam logic [511:0] EXP_1X1024 = 512'h00;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    ccip_lane_sum_engine_if if8 ();
    ccip_lane_sum_engine_if if32 ();

    ccip_lane_sum_engine #(.ELEM_W(8), .MAX_LINES(1024), .MAX_OUTSTANDING(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .bus(if8)
    );
    ccip_lane_sum_engine #(.ELEM_W(32), .MAX_LINES(1024), .MAX_OUTSTANDING(8)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .bus(if32)
    );

    logic         sel, csr_valid, rd_almfull, wr_almfull, rsp_valid;
    logic [1:0]   csr_idx;
    logic [63:0]  csr_data;
    logic [511:0] rsp_data;

    assign if8.csr_wr_valid  = csr_valid & ~sel;
    assign if32.csr_wr_valid = csr_valid & sel;
    assign if8.csr_wr_idx    = csr_idx;
    assign if32.csr_wr_idx   = csr_idx;
    assign if8.csr_wr_data   = csr_data;
    assign if32.csr_wr_data  = csr_data;
    assign if8.rd_almfull    = rd_almfull;
    assign if32.rd_almfull   = rd_almfull;
    assign if8.wr_almfull    = wr_almfull;
    assign if32.wr_almfull   = wr_almfull;
    assign if8.rd_rsp_valid  = rsp_valid & ~sel;
    assign if32.rd_rsp_valid = rsp_valid & sel;
    assign if8.rd_rsp_data   = rsp_data;
    assign if32.rd_rsp_data  = rsp_data;

    logic         m_busy, m_done, m_err, m_rd_v, m_wr_v;
    logic [41:0]  m_rd_addr, m_wr_addr;
    logic [15:0]  m_rd_mdata;
    logic [511:0] m_wr_data;

    assign m_busy     = sel ? if32.busy         : if8.busy;
    assign m_done     = sel ? if32.done         : if8.done;
    assign m_err      = sel ? if32.err          : if8.err;
    assign m_rd_v     = sel ? if32.rd_req_valid : if8.rd_req_valid;
    assign m_rd_addr  = sel ? if32.rd_req_addr  : if8.rd_req_addr;
    assign m_rd_mdata = sel ? if32.rd_req_mdata : if8.rd_req_mdata;
    assign m_wr_v     = sel ? if32.wr_req_valid : if8.wr_req_valid;
    assign m_wr_addr  = sel ? if32.wr_req_addr  : if8.wr_req_addr;
    assign m_wr_data  = sel ? if32.wr_req_data  : if8.wr_req_data;

    int n_checks = 0;
    int n_errors = 0;
    int n_rd = 0, n_wr = 0, n_rsp = 0, max_outst = 0, almfull_viol = 0;
    int sent_cnt, base_rd, base_wr;
    logic         rd_af_prev = 1'b0, wr_af_prev = 1'b0;
    logic [41:0]  req_q[$];
    logic [41:0]  addr_log[$];
    logic [41:0]  wr_addr_last = '0;
    logic [511:0] wr_data_last = '0;
    logic [511:0] fill_line;
    logic         fill_by_addr;
    logic [41:0]  cur_src;

    // host-side monitor: records requests, writes and almfull violations
    always @(negedge clk) begin
        if (reset_n) begin
            if (m_rd_v) begin
                req_q.push_back(m_rd_addr);
                n_rd++;
                if (rd_af_prev) almfull_viol++;
            end
            if (m_wr_v) begin
                n_wr++;
                wr_addr_last = m_wr_addr;
                wr_data_last = m_wr_data;
                if (wr_af_prev) almfull_viol++;
            end
            if (rsp_valid && m_busy) n_rsp++;
            if (n_rd - n_rsp > max_outst) max_outst = n_rd - n_rsp;
        end
        rd_af_prev = rd_almfull;
        wr_af_prev = wr_almfull;
    end

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic csr_wr(input logic [1:0] idx, input logic [63:0] data);
        csr_valid = 1'b1;
        csr_idx   = idx;
        csr_data  = data;
        tick();
        csr_valid = 1'b0;
    endtask

    function automatic logic [511:0] line_for(input logic [41:0] a);
        if (fill_by_addr) return {16{32'(a - cur_src + 42'd1)}};
        return fill_line;
    endfunction

    // answer queued requests in issue order, one per cycle
    task automatic serve(input int nrsp, input int cycles);
        logic [41:0] a;
        for (int c = 0; c < cycles && sent_cnt < nrsp; c++) begin
            if (req_q.size() > 0) begin
                a = req_q.pop_front();
                addr_log.push_back(a);
                rsp_valid = 1'b1;
                rsp_data  = line_for(a);
                sent_cnt++;
            end else begin
                rsp_valid = 1'b0;
            end
            tick();
        end
        rsp_valid = 1'b0;
    endtask

    task automatic wait_write(input int base, input int budget);
        for (int c = 0; c < budget && n_wr == base; c++) tick();
    endtask

    task automatic job_prep();
        req_q.delete();
        addr_log.delete();
        sent_cnt = 0;
        base_rd  = n_rd;
        base_wr  = n_wr;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0; csr_valid = 1'b0; csr_idx = '0; csr_data = '0;
        rd_almfull = 1'b0; wr_almfull = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        fill_line = '0; fill_by_addr = 1'b0; cur_src = '0; sent_cnt = 0;
        base_rd = 0; base_wr = 0;
        reset_n = 1'b0;
        ticks(3);
        reset_n = 1'b1;
        tick();

        check_eq("rst_flags8", {if8.busy, if8.done, if8.err, if8.rd_req_valid, if8.wr_req_valid}, '0);
        check_eq("rst_flags32", {if32.busy, if32.done, if32.err, if32.rd_req_valid, if32.wr_req_valid}, '0);
        check_eq("rst_acc8", if8.wr_req_data, '0);
        check_eq("rst_addr32", {if32.wr_req_addr, if32.rd_req_addr, if32.rd_req_mdata}, '0);

        // 8-bit lanes, one line, cycle-exact latency
        csr_wr(CSR_SRC, 64'h100);
        csr_wr(CSR_DST, 64'h200);
        job_prep();
        csr_wr(CSR_START, 64'd1);
        tick();
        check_eq("n1_req", {m_rd_v, m_busy, m_rd_addr, m_rd_mdata}, {1'b1, 1'b1, 42'h100, 16'h0});
        rsp_valid = 1'b1;
        rsp_data  = 512'h0705;
        tick();
        rsp_valid = 1'b0;
        check_eq("n1_no_early_wr", {m_wr_v, m_busy}, 2'b01);
        tick();
        check_eq("n1_wr", {m_wr_v, m_wr_addr}, {1'b1, 42'h200});
        check_eq("n1_data", m_wr_data, 512'h0705);
        tick();
        check_eq("n1_done", {m_wr_v, m_busy, m_done}, 3'b001);

        // two lines of 0xF0 in lane 0, source address wraps past 2^42
        csr_wr(CSR_SRC, 64'h3FF_FFFF_FFFF);
        csr_wr(CSR_DST, 64'h300);
        job_prep();
        fill_line = 512'hF0;
        csr_wr(CSR_START, 64'd2);
        serve(2, 50);
        wait_write(base_wr, 20);
        check_eq("sat_data", wr_data_last, EXP_F0X2);
        check_eq("wrap_addr0", addr_log.size() > 0 ? addr_log[0] : 42'h0, 42'h3FF_FFFF_FFFF);
        check_eq("wrap_addr1", addr_log.size() > 1 ? addr_log[1] : 42'h1, 42'h0);
        ticks(3);

        // 32-bit lanes, 16 lines, outstanding limit and reversed completion
        sel = 1'b1;
        tick();
        csr_wr(CSR_SRC, 64'h1000);
        csr_wr(CSR_DST, 64'h2000);
        job_prep();
        max_outst = 0;
        csr_wr(CSR_START, 64'd16);
        ticks(20);
        check_eq("n16_batch1", 32'(req_q.size()), 32'd8);
        check_eq("n16_first", req_q.size() == 8 ? {req_q[7], req_q[0]} : '0, {42'h1007, 42'h1000});
        req_q.delete();
        for (int k = 7; k >= 0; k--) begin
            rsp_valid = 1'b1;
            rsp_data  = {16{32'd1}};
            tick();
        end
        rsp_valid = 1'b0;
        ticks(20);
        check_eq("n16_batch2", 32'(req_q.size()), 32'd8);
        req_q.delete();
        for (int k = 7; k >= 0; k--) begin
            rsp_valid = 1'b1;
            rsp_data  = {16{32'd1}};
            tick();
        end
        rsp_valid = 1'b0;
        wait_write(base_wr, 20);
        check_eq("n16_data", wr_data_last, {16{32'd16}});
        check_eq("n16_wr_addr", wr_addr_last, 42'h2000);
        check_eq("n16_max_outst", 32'(max_outst), 32'd8);
        check_eq("n16_reads", 32'(n_rd - base_rd), 32'd16);
        ticks(3);

        // N=0: a single all-zero write and no reads
        sel = 1'b0;
        tick();
        csr_wr(CSR_DST, 64'h400);
        job_prep();
        csr_wr(CSR_START, 64'd0);
        tick();
        check_eq("n0_wr_pulse", m_wr_v, 1'b1);
        ticks(5);
        check_eq("n0_traffic", {32'(n_wr - base_wr), 32'(n_rd - base_rd)}, {32'd1, 32'd0});
        check_eq("n0_data", {wr_addr_last, wr_data_last}, {42'h400, 512'h0});
        check_eq("n0_done", m_done, 1'b1);

        // one line too many: error, no traffic, clear via idx 3
        job_prep();
        csr_wr(CSR_START, 64'd1025);
        tick();
        check_eq("big_err", {m_busy, m_err}, 2'b01);
        ticks(10);
        check_eq("big_traffic", {32'(n_wr - base_wr), 32'(n_rd - base_rd)}, '0);
        csr_wr(CSR_CLEAR, 64'd0);
        check_eq("clr_flags", {m_done, m_err}, 2'b00);

        // exactly MAX_LINES is legal
        csr_wr(CSR_SRC, 64'h8000);
        job_prep();
        fill_line = 512'h01;
        csr_wr(CSR_START, 64'd1024);
        tick();
        check_eq("max_ok", {m_busy, m_err}, 2'b10);
        serve(1024, 3000);
        wait_write(base_wr, 20);
        check_eq("max_reads", 32'(n_rd - base_rd), 32'd1024);
        check_eq("max_data", wr_data_last, EXP_1X1024);
        ticks(3);

        // backpressure on both channels, distinct data per line
        sel = 1'b1;
        tick();
        csr_wr(CSR_SRC, 64'h40);
        csr_wr(CSR_DST, 64'h80);
        job_prep();
        almfull_viol = 0;
        fill_by_addr = 1'b1;
        cur_src = 42'h40;
        csr_wr(CSR_START, 64'd12);
        ticks(2);
        rd_almfull = 1'b1;
        serve(12, 20);
        rd_almfull = 1'b0;
        wr_almfull = 1'b1;
        serve(12, 200);
        ticks(5);
        check_eq("af_wr_held", 32'(n_wr - base_wr), 32'd0);
        wr_almfull = 1'b0;
        wait_write(base_wr, 20);
        check_eq("af_data", wr_data_last, {16{32'd78}});
        check_eq("af_viol", 32'(almfull_viol), 32'd0);
        check_eq("af_reads", 32'(n_rd - base_rd), 32'd12);
        fill_by_addr = 1'b0;
        ticks(3);

        // reset with three reads outstanding, then stale responses
        csr_wr(CSR_SRC, 64'h500);
        csr_wr(CSR_DST, 64'h600);
        job_prep();
        csr_wr(CSR_START, 64'd3);
        ticks(5);
        check_eq("rst_job_outst", 32'(req_q.size()), 32'd3);
        reset_n = 1'b0;
        ticks(2);
        reset_n = 1'b1;
        job_prep();
        for (int k = 0; k < 3; k++) begin
            rsp_valid = 1'b1;
            rsp_data  = {16{32'd9}};
            tick();
        end
        rsp_valid = 1'b0;
        ticks(3);
        check_eq("rst_idle", {m_busy, m_done, m_wr_v}, 3'b000);
        check_eq("rst_no_wr", 32'(n_wr - base_wr), 32'd0);
        check_eq("rst_acc", m_wr_data, '0);
        fill_line = {16{32'd3}};
        csr_wr(CSR_START, 64'd1);
        serve(1, 20);
        wait_write(base_wr, 20);
        check_eq("post_rst_data", wr_data_last, {16{32'd3}});
        check_eq("post_rst_addr", {addr_log.size() > 0 ? addr_log[0] : 42'h1, wr_addr_last}, '0);

        ticks(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
